// File: rtl/ising_sweep_scheduler.sv
// Checkerboard Metropolis sweep sequencer with a stepped annealing schedule.
// Ports: clk/rst_n; start/abort with run settings; upd_* row-command handshake; temperature, sweep_count, busy, done status.
module ising_sweep_scheduler #(
  parameter int LATTICE_SIZE   = 16,
  parameter int TEMP_WIDTH     = 8,
  parameter int SWEEP_WIDTH    = 16,
  parameter int STEPS_PER_TEMP = 4,
  localparam int ROW_W = $clog2(LATTICE_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [SWEEP_WIDTH-1:0] num_sweeps,
  input  logic [TEMP_WIDTH-1:0]  temp_start,
  input  logic [TEMP_WIDTH-1:0]  temp_step,
  input  logic [TEMP_WIDTH-1:0]  temp_min,
  output logic                   upd_valid,
  input  logic                   upd_ready,
  output logic [ROW_W-1:0]       row_addr,
  output logic                   col_parity,
  output logic [TEMP_WIDTH-1:0]  temperature,
  output logic [SWEEP_WIDTH-1:0] sweep_count,
  output logic                   busy,
  output logic                   done
);

  localparam int ANN_W = (STEPS_PER_TEMP > 1) ? $clog2(STEPS_PER_TEMP) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(LATTICE_SIZE - 1);
  localparam logic [ANN_W-1:0] ANN_LAST = ANN_W'(STEPS_PER_TEMP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVEN,
    S_ODD,
    S_ANNEAL,
    S_DONE
  } state_t;

  state_t                 r_state, w_state_n;
  logic [ROW_W-1:0]       r_row, w_row_n;
  logic [TEMP_WIDTH-1:0]  r_temp, w_temp_n;
  logic [SWEEP_WIDTH-1:0] r_sweep, w_sweep_n;
  logic [ANN_W-1:0]       r_ann, w_ann_n;
  logic [SWEEP_WIDTH-1:0] r_num, w_num_n;
  logic [TEMP_WIDTH-1:0]  r_step, w_step_n;
  logic [TEMP_WIDTH-1:0]  r_min, w_min_n;
  logic                   r_valid, w_valid_n;
  logic                   r_par, w_par_n;
  logic                   r_busy, w_busy_n;
  logic                   r_done, w_done_n;

  logic                   w_xfer;
  logic [SWEEP_WIDTH-1:0] w_sweep_inc;
  logic [TEMP_WIDTH:0]    w_limit;
  logic                   w_sat;
  logic [TEMP_WIDTH-1:0]  w_temp_dec;

  assign w_xfer      = r_valid & upd_ready;
  assign w_sweep_inc = r_sweep + SWEEP_WIDTH'(1);
  // One extra bit so min+step cannot wrap.
  assign w_limit     = {1'b0, r_min} + {1'b0, r_step};
  assign w_sat       = ({1'b0, r_temp} <= w_limit);
  assign w_temp_dec  = w_sat ? r_min : (r_temp - r_step);

  always_comb begin
    w_state_n = r_state;
    w_row_n   = r_row;
    w_temp_n  = r_temp;
    w_sweep_n = r_sweep;
    w_ann_n   = r_ann;
    w_num_n   = r_num;
    w_step_n  = r_step;
    w_min_n   = r_min;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_num_n   = num_sweeps;
          w_step_n  = temp_step;
          w_min_n   = temp_min;
          w_temp_n  = temp_start;
          w_sweep_n = '0;
          w_ann_n   = '0;
          w_row_n   = '0;
          w_state_n = (num_sweeps == '0) ? S_DONE : S_EVEN;
        end
      end
      S_EVEN, S_ODD: begin
        if (abort) begin
          w_state_n = S_IDLE;
        end else if (w_xfer) begin
          if (r_row == ROW_LAST) begin
            w_row_n   = '0;
            w_state_n = (r_state == S_EVEN) ? S_ODD : S_ANNEAL;
          end else begin
            w_row_n = r_row + ROW_W'(1);
          end
        end
      end
      S_ANNEAL: begin
        if (abort) begin
          w_state_n = S_IDLE;
        end else begin
          w_sweep_n = w_sweep_inc;
          if (r_ann == ANN_LAST) begin
            w_ann_n  = '0;
            w_temp_n = w_temp_dec;
          end else begin
            w_ann_n = r_ann + ANN_W'(1);
          end
          w_state_n = (w_sweep_inc == r_num) ? S_DONE : S_EVEN;
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
    // Outputs are registered: derive them from the next state.
    w_valid_n = (w_state_n == S_EVEN) || (w_state_n == S_ODD);
    w_par_n   = (w_state_n == S_ODD) ^ w_row_n[0];
    w_busy_n  = (w_state_n != S_IDLE);
    w_done_n  = (w_state_n == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_temp  <= '0;
      r_sweep <= '0;
      r_ann   <= '0;
      r_num   <= '0;
      r_step  <= '0;
      r_min   <= '0;
      r_valid <= 1'b0;
      r_par   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_row   <= w_row_n;
      r_temp  <= w_temp_n;
      r_sweep <= w_sweep_n;
      r_ann   <= w_ann_n;
      r_num   <= w_num_n;
      r_step  <= w_step_n;
      r_min   <= w_min_n;
      r_valid <= w_valid_n;
      r_par   <= w_par_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  assign upd_valid   = r_valid;
  assign row_addr    = r_row;
  assign col_parity  = r_par;
  assign temperature = r_temp;
  assign sweep_count = r_sweep;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_ising_sweep_scheduler.sv
// Directed bench for ising_sweep_scheduler on a 4x4 lattice.
// Instance a anneals every sweep, instance b every 4 sweeps; both share stimulus.
module tb_ising_sweep_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] num_sweeps = '0;
  logic [7:0]  temp_start = '0;
  logic [7:0]  temp_step = '0;
  logic [7:0]  temp_min = '0;
  logic        upd_ready = 1'b1;

  logic        a_valid, b_valid;
  logic [1:0]  a_row, b_row;
  logic        a_par, b_par;
  logic [7:0]  a_temp, b_temp;
  logic [15:0] a_sweep, b_sweep;
  logic        a_busy, b_busy;
  logic        a_done, b_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  ising_sweep_scheduler #(
    .LATTICE_SIZE(4), .TEMP_WIDTH(8),
    .SWEEP_WIDTH(16), .STEPS_PER_TEMP(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_sweeps(num_sweeps), .temp_start(temp_start),
    .temp_step(temp_step), .temp_min(temp_min),
    .upd_valid(a_valid), .upd_ready(upd_ready),
    .row_addr(a_row), .col_parity(a_par),
    .temperature(a_temp), .sweep_count(a_sweep),
    .busy(a_busy), .done(a_done)
  );

  ising_sweep_scheduler #(
    .LATTICE_SIZE(4), .TEMP_WIDTH(8),
    .SWEEP_WIDTH(16), .STEPS_PER_TEMP(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_sweeps(num_sweeps), .temp_start(temp_start),
    .temp_step(temp_step), .temp_min(temp_min),
    .upd_valid(b_valid), .upd_ready(upd_ready),
    .row_addr(b_row), .col_parity(b_par),
    .temperature(b_temp), .sweep_count(b_sweep),
    .busy(b_busy), .done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input int n, input int ts, input int st, input int mn);
    num_sweeps = 16'(n);
    temp_start = 8'(ts);
    temp_step  = 8'(st);
    temp_min   = 8'(mn);
    start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    while (a_done !== 1'b1 && cyc < limit) tick();
  endtask

  int rows[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int pars[8] = '{0, 1, 0, 1, 1, 0, 1, 0};
  int t1[2]   = '{90, 80};
  int sat[4]  = '{15, 8, 8, 8};
  int bt[8]   = '{50, 50, 50, 45, 45, 45, 45, 40};
  int dcount;

  initial begin
    #2;
    chk("rst_valid", a_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_temp", a_temp, 0);
    chk("rst_sweep", a_sweep, 0);
    chk("rst_row", a_row, 0);
    #10 rst_n = 1'b1;
    tick();

    // basic two-sweep run
    upd_ready = 1'b1;
    go(2, 100, 10, 0);
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("t1_valid_s%0d_%0d", s, i), a_valid, 1);
        chk($sformatf("t1_row_s%0d_%0d", s, i), a_row, rows[i]);
        chk($sformatf("t1_par_s%0d_%0d", s, i), a_par, pars[i]);
        tick();
      end
      chk("t1_anneal_valid", a_valid, 0);
      chk("t1_anneal_busy", a_busy, 1);
      tick();
      chk($sformatf("t1_temp_s%0d", s), a_temp, t1[s]);
      chk($sformatf("t1_sweep_s%0d", s), a_sweep, s + 1);
    end
    chk("t1_done_c19", a_done, 1);
    chk("t1_b_temp", b_temp, 100);
    tick();
    chk("t1_done_clr", a_done, 0);
    chk("t1_idle_busy", a_busy, 0);
    chk("t1_hold_temp", a_temp, 80);

    // backpressure on EVEN row 2
    go(1, 100, 10, 0);
    tick();
    tick();
    upd_ready = 1'b0;
    chk("t2_row_c3", a_row, 2);
    tick();
    chk("t2_row_c4", a_row, 2);
    chk("t2_par_c4", a_par, 0);
    chk("t2_valid_c4", a_valid, 1);
    tick();
    chk("t2_row_c5", a_row, 2);
    tick();
    chk("t2_row_c6", a_row, 2);
    chk("t2_par_c6", a_par, 0);
    upd_ready = 1'b1;
    tick();
    chk("t2_row_c7", a_row, 3);
    wait_done(60);
    chk("t2_done_cycle", cyc, 13);
    tick();

    // saturation at the floor
    go(4, 25, 10, 8);
    for (int s = 0; s < 4; s++) begin
      repeat (9) tick();
      chk($sformatf("t3_temp_s%0d", s), a_temp, sat[s]);
      if (s == 2) chk("t3_b_temp_s2", b_temp, 25);
    end
    chk("t3_b_temp_s3", b_temp, 15);
    chk("t3_done", a_done, 1);
    chk("t3_sweep", a_sweep, 4);
    tick();

    // four sweeps per temperature step
    go(8, 50, 5, 0);
    for (int s = 0; s < 8; s++) begin
      repeat (9) tick();
      chk($sformatf("t4_b_temp_s%0d", s), b_temp, bt[s]);
    end
    chk("t4_a_temp", a_temp, 10);
    chk("t4_b_done", b_done, 1);
    chk("t4_b_sweep", b_sweep, 8);
    tick();

    // zero sweeps, then start ignored while busy
    go(0, 70, 5, 0);
    chk("t5_busy", a_busy, 1);
    chk("t5_done", a_done, 1);
    chk("t5_valid", a_valid, 0);
    chk("t5_temp", a_temp, 70);
    tick();
    chk("t5_busy_clr", a_busy, 0);
    chk("t5_done_clr", a_done, 0);
    chk("t5_valid_clr", a_valid, 0);
    go(3, 70, 5, 0);
    repeat (4) tick();
    num_sweeps = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(120);
    chk("t5_done_cycle", cyc, 28);
    chk("t5_sweep", a_sweep, 3);
    tick();

    // abort in ODD row 1 of first sweep
    go(2, 100, 10, 0);
    repeat (5) tick();
    chk("t6_row", a_row, 1);
    chk("t6_par", a_par, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_valid", a_valid, 0);
    chk("t6_busy", a_busy, 0);
    chk("t6_done", a_done, 0);
    chk("t6_sweep", a_sweep, 0);
    chk("t6_temp", a_temp, 100);
    dcount = 0;
    repeat (12) begin
      tick();
      if (a_done === 1'b1) dcount++;
    end
    chk("t6_no_done", dcount, 0);

    // start beats abort in IDLE, then async reset mid-run
    num_sweeps = 16'd2;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("t7_busy", a_busy, 1);
    chk("t7_valid", a_valid, 1);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", a_valid, 0);
    chk("t7_rst_busy", a_busy, 0);
    chk("t7_rst_row", a_row, 0);
    chk("t7_rst_par", a_par, 0);
    chk("t7_rst_temp", a_temp, 0);
    chk("t7_rst_sweep", a_sweep, 0);
    chk("t7_rst_done", a_done, 0);
    #20 rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
